// File: rtl/adc_frame_sequencer.sv
// Frame sequencer: turns CASCOUT edges into settled column write strobes for a
// ping-pong pair of 8 x M_SAMPLES frame buffers and hands full banks to the consumer.
module adc_frame_sequencer #(
    parameter int M_SAMPLES   = 512,
    parameter int SETTLE_CYC  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         CASCOUT,
    output logic                         wr_en,
    output logic                         wr_bank,
    output logic [$clog2(M_SAMPLES)-1:0] wr_col,
    output logic                         frame_ready,
    output logic                         frame_bank,
    input  logic                         frame_ack,
    output logic                         overrun,
    output logic [15:0]                  drop_cnt,
    output logic                         busy
);
    localparam int COL_W = $clog2(M_SAMPLES);
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]             state;
    logic [CNT_W-1:0]       settle_cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev;
    logic                   cas_edge;
    logic [1:0]             bank_full;
    logic [1:0]             full_nxt;
    logic                   ack_valid;
    logic                   in_write;
    logic                   bank_free;
    logic                   do_write;
    logic                   last_col;
    logic                   drop_write;
    logic                   drop_edge;
    logic [1:0]             drop_inc;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, a} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // CASCOUT is asynchronous; only the last synchroniser stage feeds the edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], CASCOUT};
            sync_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign cas_edge = sync_q[SYNC_STAGES-1] & ~sync_prev;

    // An ack frees the presented bank in the same cycle, so a write to it can proceed.
    assign ack_valid  = frame_ack & frame_ready;
    assign in_write   = (state == S_WRITE);
    assign bank_free  = ~bank_full[wr_bank] | (ack_valid & (frame_bank == wr_bank));
    assign do_write   = in_write & bank_free;
    assign drop_write = in_write & ~bank_free;
    assign last_col   = (wr_col == COL_W'(M_SAMPLES - 1));
    assign drop_edge  = cas_edge & ((state == S_SETTLE) | (state == S_WRITE));
    assign drop_inc   = {1'b0, drop_write} + {1'b0, drop_edge};

    assign wr_en = do_write;
    assign busy  = (state != S_IDLE);

    always_comb begin
        full_nxt = bank_full;
        if (ack_valid) full_nxt[frame_bank] = 1'b0;
        if (do_write && last_col) full_nxt[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (cas_edge) begin
                        state      <= S_SETTLE;
                        settle_cnt <= CNT_W'(SETTLE_CYC - 1);
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) state <= S_WRITE;
                    else settle_cnt <= settle_cnt - CNT_W'(1);
                end
                S_WRITE: begin
                    state <= (do_write && last_col) ? S_DONE : S_WAIT;
                end
                S_DONE: begin
                    state <= S_WAIT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_col  <= '0;
            wr_bank <= 1'b0;
        end else begin
            if (do_write) wr_col <= last_col ? '0 : wr_col + COL_W'(1);
            if (state == S_DONE) wr_bank <= ~wr_bank;
        end
    end

    // A second full bank waits behind the presented one and is shown on its ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full   <= 2'b00;
            frame_ready <= 1'b0;
            frame_bank  <= 1'b0;
        end else begin
            bank_full <= full_nxt;
            if (ack_valid) begin
                if (bank_full[~frame_bank]) frame_bank <= ~frame_bank;
                else frame_ready <= 1'b0;
            end else if (state == S_DONE && !frame_ready) begin
                frame_ready <= 1'b1;
                frame_bank  <= wr_bank;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun  <= 1'b0;
            drop_cnt <= '0;
        end else if (drop_inc != 2'd0) begin
            overrun  <= 1'b1;
            drop_cnt <= sat_add(drop_cnt, drop_inc);
        end
    end
endmodule

// File: tb/tb_adc_frame_sequencer.sv
// Directed bench for adc_frame_sequencer with a timestamp-based reference model
// checked every cycle, plus literal expectations at the end of each scenario.
module tb_adc_frame_sequencer;
    localparam int M  = 512;
    localparam int SC = 3;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         CASCOUT;
    logic         frame_ack;
    logic         wr_en;
    logic         wr_bank;
    logic [8:0]   wr_col;
    logic         frame_ready;
    logic         frame_bank;
    logic         overrun;
    logic [15:0]  drop_cnt;
    logic         busy;

    adc_frame_sequencer #(.M_SAMPLES(M), .SETTLE_CYC(SC), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .CASCOUT(CASCOUT),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_col(wr_col),
        .frame_ready(frame_ready), .frame_bank(frame_bank), .frame_ack(frame_ack),
        .overrun(overrun), .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int phase = 0;
    int rise_cyc = 0;
    int wr_cnt = 0;
    int last_col = -1;
    int last_bank = -1;

    // Reference model: write/done moments are absolute cycle stamps, -1 = none pending.
    bit [7:0] m_hist = '0;
    bit [1:0] m_full = '0;
    int  m_col = 0, m_drops = 0, m_wat = -1, m_dat = -1;
    bit  m_bank = 0, m_ready = 0, m_fbank = 0, m_ovr = 0, m_eng = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        bit ed, ack_eff, is_wr, free, wr_exp, was_ready;
        int dadd;
        if (!rst_n) begin
            m_hist = '0; m_full = '0; m_col = 0; m_drops = 0; m_wat = -1; m_dat = -1;
            m_bank = 0; m_ready = 0; m_fbank = 0; m_ovr = 0; m_eng = 0;
        end else begin
            m_hist = {m_hist[6:0], CASCOUT};
        end
        ed      = rst_n && m_hist[SS] && !m_hist[SS+1];
        ack_eff = rst_n && frame_ack && m_ready;
        is_wr   = rst_n && (m_wat == cyc);
        free    = !m_full[m_bank] || (ack_eff && (m_fbank == m_bank));
        wr_exp  = is_wr && free;

        chk("wr_en", wr_en, wr_exp);
        chk("wr_bank", wr_bank, m_bank);
        chk("wr_col", wr_col, m_col);
        chk("frame_ready", frame_ready, m_ready);
        chk("frame_bank", frame_bank, m_fbank);
        chk("overrun", overrun, m_ovr);
        chk("drop_cnt", drop_cnt, m_drops);
        chk("busy", busy, m_eng);

        if (wr_en === 1'b1) begin
            if (phase == 1) begin
                chk("p1_latency", cyc - rise_cyc, SS + 1 + SC);
                chk("p1_col_seq", wr_col, wr_cnt);
            end
            wr_cnt++;
            last_col  = wr_col;
            last_bank = wr_bank;
        end

        if (rst_n) begin
            dadd = 0;
            was_ready = m_ready;
            if (is_wr && !free) dadd++;
            if (ed && m_wat >= 0) dadd++;
            if (ack_eff) begin
                m_full[m_fbank] = 1'b0;
                if (m_full[!m_fbank]) m_fbank = !m_fbank;
                else m_ready = 0;
            end
            if (is_wr) begin
                m_wat = -1;
                if (wr_exp) begin
                    if (m_col == M - 1) begin
                        m_col = 0;
                        m_full[m_bank] = 1'b1;
                        m_dat = cyc + 1;
                    end else begin
                        m_col++;
                    end
                end
            end else if (m_dat == cyc) begin
                if (!was_ready) begin
                    m_ready = 1;
                    m_fbank = m_bank;
                end
                m_bank = !m_bank;
                m_dat = -1;
            end else if (!m_eng) begin
                if (enable) m_eng = 1;
            end else if (m_wat < 0) begin
                if (!enable) m_eng = 0;
                else if (ed) m_wat = cyc + SC + 1;
            end
            if (dadd > 0) begin
                m_ovr = 1;
                m_drops = (m_drops + dadd > 65535) ? 65535 : m_drops + dadd;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulses(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            CASCOUT = 1'b1;
            rise_cyc = cyc;
            tick();
            CASCOUT = 1'b0;
            repeat (gap - 1) tick();
        end
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        tick();
    endtask

    initial begin
        int c0;
        rst_n = 1'b0; enable = 1'b0; CASCOUT = 1'b0; frame_ack = 1'b0;
        repeat (3) tick();
        chk("reset_busy", busy, 0);
        chk("reset_wr_col", wr_col, 0);
        rst_n = 1'b1;
        tick();

        // 1: one full frame into bank 0
        phase = 1;
        enable = 1'b1;
        tick();
        pulses(512, 20);
        repeat (5) tick();
        phase = 0;
        chk("p1_writes", wr_cnt, 512);
        chk("p1_last_col", last_col, 511);
        chk("p1_ready", frame_ready, 1);
        chk("p1_fbank", frame_bank, 0);
        chk("p1_wr_bank", wr_bank, 1);

        // 2: bank 1 fills behind the unacked bank 0
        pulses(512, 10);
        repeat (5) tick();
        chk("p2_writes", wr_cnt, 1024);
        chk("p2_fbank", frame_bank, 0);
        ack();
        chk("p2_ack1_ready", frame_ready, 1);
        chk("p2_ack1_fbank", frame_bank, 1);
        ack();
        chk("p2_ack2_ready", frame_ready, 0);

        // 3: both banks fill, six samples dropped
        pulses(1030, 10);
        repeat (5) tick();
        chk("p3_writes", wr_cnt, 2048);
        chk("p3_drops", drop_cnt, 6);
        chk("p3_overrun", overrun, 1);
        ack();
        pulses(1, 10);
        chk("p3_resume_bank", last_bank, 0);
        chk("p3_resume_col", last_col, 0);
        chk("p3_writes_after", wr_cnt, 2049);

        // 4: edges every 3 clks, every other one lands in SETTLE/WRITE
        pulses(20, 3);
        repeat (10) tick();
        chk("p4_drops", drop_cnt, 16);
        chk("p4_writes", wr_cnt, 2059);
        chk("p4_last_col", last_col, 10);

        // 5: reset mid-frame
        pulses(189, 10);
        chk("p5_col_before", wr_col, 200);
        rst_n = 1'b0;
        #1;
        chk("p5_rst_wr_en", wr_en, 0);
        chk("p5_rst_col", wr_col, 0);
        chk("p5_rst_ready", frame_ready, 0);
        chk("p5_rst_overrun", overrun, 0);
        chk("p5_rst_drops", drop_cnt, 0);
        chk("p5_rst_busy", busy, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        pulses(1, 10);
        chk("p5_restart_bank", last_bank, 0);
        chk("p5_restart_col", last_col, 0);

        // 6: pause mid-frame and resume in place
        pulses(99, 10);
        chk("p6_col_before", wr_col, 100);
        enable = 1'b0;
        repeat (3) tick();
        c0 = wr_cnt;
        pulses(50, 10);
        chk("p6_no_writes", wr_cnt - c0, 0);
        chk("p6_idle_busy", busy, 0);
        enable = 1'b1;
        repeat (2) tick();
        pulses(1, 10);
        chk("p6_resume_col", last_col, 100);
        chk("p6_resume_bank", last_bank, 0);
        chk("p6_next_col", wr_col, 101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/adc_frame_sequencer.md
Name: adc_frame_sequencer

Overview:
- Synchronous controller that sequences accumulation of dual-ADC sample vectors into a ping-pong pair of 8 x M frame buffers.
- Detects each CASCOUT rising edge and waits a settle interval so ADC words are valid.
- Issues one capture/write strobe with a column index per edge, and hands completed frames to the downstream separation/ICA stage through a ready/ack handshake.
- Sits between the ADC collectors and the frame-buffer RAM; it never touches sample data, only addresses, strobes and bank ownership.

Parameters:
- M_SAMPLES, 512, columns per frame (power of two, >= 4).
- SETTLE_CYC, 3, clk cycles from detected CASCOUT edge to write strobe (>= 1).
- SYNC_STAGES, 2, synchroniser flops on CASCOUT (>= 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; 1 = accept samples, 0 = finish current write then idle.
- CASCOUT  in  1  ADC cascade-out, asynchronous to clk.
- wr_en  out  1  one-cycle write strobe to frame RAM (all 8 channels this column).
- wr_bank  out  1  bank being written.
- wr_col  out  $clog2(M_SAMPLES)  column index of current write.
- frame_ready  out  1  level; a full frame is held for the consumer.
- frame_bank  out  1  bank holding the presented frame.
- frame_ack  in  1  one-cycle pulse; consumer has finished reading frame_bank.
- overrun  out  1  sticky; at least one sample was dropped.
- drop_cnt  out  16  saturating count of dropped samples.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync deassert via clk): state IDLE.
  - wr_en=0, wr_bank=0, wr_col=0.
  - frame_ready=0, frame_bank=0.
  - overrun=0, drop_cnt=0, busy=0.
  - Both banks marked free; synchroniser flops cleared.
- Edge detect: CASCOUT passes through SYNC_STAGES flops. edge = sync_out & ~sync_prev.
  - Latency from CASCOUT rise to edge is SYNC_STAGES+1 clks.
- IDLE: when enable=1, go to WAIT_EDGE.
- WAIT_EDGE: on edge, go to SETTLE and load the settle counter with SETTLE_CYC-1. On enable=0, go to IDLE.
- SETTLE: decrement the counter; at 0, go to WRITE. An edge arriving during SETTLE or WRITE is ignored and counted as a drop.
- WRITE (1 cycle):
  - If the write bank is free: wr_en=1 with the current wr_bank/wr_col; wr_col increments afterwards.
  - If wr_col was M_SAMPLES-1: wr_col wraps to 0, the bank is marked full, and the state goes to FRAME_DONE. Otherwise the state returns to WAIT_EDGE.
- FRAME_DONE (1 cycle):
  - If frame_ready=0: frame_ready<=1 and frame_bank<=the just-filled bank.
  - Otherwise the frame stays queued and is presented on the ack cycle of the prior frame.
  - wr_bank toggles. Next state is WAIT_EDGE.
- Drop rule: in WRITE with the target bank still full (consumer has not acked it):
  - no wr_en, wr_col unchanged;
  - overrun<=1, drop_cnt += 1 (saturates at 16'hFFFF).
- frame_ack:
  - Frees frame_bank the same cycle; frame_ready drops next cycle.
  - If the other bank is full, frame_ready stays 1 and frame_bank switches to it next cycle.
  - frame_ack while frame_ready=0 is ignored.
  - frame_ack coinciding with a WRITE to the same bank: the free takes effect first, so the write proceeds.
- enable=0 mid-frame: wr_col and bank state are retained; resuming continues the same frame.
- Reset mid-frame: partial frame discarded, all state as at reset.
- overrun and drop_cnt clear only on reset.

Test Plan:
1. Reset, enable=1, 512 CASCOUT pulses spaced 20 clks:
   - exactly 512 wr_en pulses, wr_col 0..511 on bank 0;
   - each wr_en occurs SYNC_STAGES+1+SETTLE_CYC clks after the CASCOUT rise;
   - frame_ready=1 with frame_bank=0 one cycle after the last write.
2. Continue 512 more pulses, no ack:
   - bank 1 fills; frame_bank stays 0;
   - ack then gives frame_bank=1 with frame_ready still 1;
   - a second ack drops frame_ready.
3. 1030 pulses with no ack:
   - both banks fill and the next 6 samples are dropped;
   - overrun=1, drop_cnt=6, no wr_en during drops;
   - ack resumes writes at bank 0, column 0.
4. CASCOUT pulses spaced 3 clks (inside SETTLE):
   - alternate edges ignored; drop_cnt increments per ignored edge; wr_col never skips.
5. Assert rst_n low at column 200: all outputs return to reset values immediately; the next frame starts at column 0 on bank 0.
6. Drop enable at column 100 for 50 pulses, then re-enable: no writes while disabled; writing resumes at column 100 on the same bank.
